// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchronized serial input, runtime-selectable 5-8 data bits,
// optional even/odd parity, 1 or 2 stop bits, single-entry holding register with ack.
module uart_rx_core #(
  parameter int BAUD_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun_error,
  output logic       rts_n
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_reg, state_next;
  logic            sync1_reg, rxs, rxs_prev_reg;
  logic [1:0]      settle_reg;
  logic [CW-1:0]   baud_cnt_reg;
  logic [2:0]      bit_cnt_reg;
  logic [1:0]      dbits_reg;
  logic            sbits_reg, pen_reg, ptype_reg;
  logic [7:0]      shift_reg;
  logic            par_bit_reg, ferr_reg;

  logic half_tick, full_tick, start_edge, last_data, last_stop, valid_next;
  logic start_frame, sample_data, sample_parity, sample_stop, finish;

  // Sync flops reset high; settle_reg keeps a line held low across reset release
  // from looking like a falling edge while the synchronizer refills.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg    <= 1'b1;
      rxs          <= 1'b1;
      rxs_prev_reg <= 1'b1;
      settle_reg   <= 2'd0;
    end else begin
      sync1_reg    <= rx;
      rxs          <= sync1_reg;
      rxs_prev_reg <= rxs;
      if (settle_reg != 2'd3)
        settle_reg <= settle_reg + 2'd1;
    end
  end

  assign half_tick  = (baud_cnt_reg == HALF_LAST);
  assign full_tick  = (baud_cnt_reg == FULL_LAST);
  assign start_edge = (settle_reg == 2'd3) && rxs_prev_reg && !rxs;
  assign last_data  = (bit_cnt_reg == ({1'b0, dbits_reg} + 3'd4));
  assign last_stop  = (bit_cnt_reg == {2'b00, sbits_reg});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_edge) state_next = START;
      START:   if (half_tick) state_next = rxs ? IDLE : DATA;
      DATA:    if (full_tick && last_data) state_next = pen_reg ? PARITY : STOP;
      PARITY:  if (full_tick) state_next = STOP;
      STOP:    if (full_tick && last_stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    start_frame   = 1'b0;
    sample_data   = 1'b0;
    sample_parity = 1'b0;
    sample_stop   = 1'b0;
    finish        = 1'b0;
    case (state_reg)
      IDLE:   start_frame   = start_edge;
      DATA:   sample_data   = full_tick;
      PARITY: sample_parity = full_tick;
      STOP: begin
        sample_stop = full_tick;
        finish      = full_tick && last_stop;
      end
      default: ;
    endcase
  end

  // START counts to mid-bit; every later slot is a full bit period from there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= 3'd0;
      dbits_reg    <= 2'd0;
      sbits_reg    <= 1'b0;
      pen_reg      <= 1'b0;
      ptype_reg    <= 1'b0;
      shift_reg    <= 8'h00;
      par_bit_reg  <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      if (state_reg == IDLE)
        baud_cnt_reg <= '0;
      else if ((state_reg == START) ? half_tick : full_tick)
        baud_cnt_reg <= '0;
      else
        baud_cnt_reg <= baud_cnt_reg + CW'(1);

      if (start_frame) begin
        bit_cnt_reg <= 3'd0;
        dbits_reg   <= data_bit_num;
        sbits_reg   <= stop_bit_num;
        pen_reg     <= parity_en;
        ptype_reg   <= parity_type;
        shift_reg   <= 8'h00;
        par_bit_reg <= 1'b0;
        ferr_reg    <= 1'b0;
      end else if (sample_data) begin
        shift_reg[bit_cnt_reg] <= rxs;
        bit_cnt_reg <= last_data ? 3'd0 : bit_cnt_reg + 3'd1;
      end else if (sample_parity) begin
        par_bit_reg <= rxs;
      end else if (sample_stop) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (!rxs) ferr_reg <= 1'b1;
      end
    end
  end

  // An ack coinciding with completion is absorbed: the new frame stays valid.
  assign valid_next = finish || (rx_valid && !rx_ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= 8'h00;
      rx_done       <= 1'b0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
      rts_n         <= 1'b0;
    end else begin
      rx_done       <= finish;
      overrun_error <= finish && rx_valid && !rx_ack;
      rx_valid      <= valid_next;
      rts_n         <= valid_next;
      if (finish) begin
        rx_data      <= shift_reg;
        parity_error <= pen_reg && (^shift_reg ^ par_bit_reg ^ ptype_reg);
        frame_error  <= ferr_reg || !rxs;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at BAUD_DIV=16: frame formats, error flags,
// glitch rejection, overrun, ack collision and reset behaviour.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [1:0] data_bit_num = 2'b11;
  logic       stop_bit_num = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_type = 1'b0;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_done, rx_valid, parity_error, frame_error, overrun_error, rts_n;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;

  int         done_cnt = 0;
  int         ovr_cnt = 0;
  int         done_cyc = 0;
  logic [7:0] done_data = 8'h00;
  logic       done_valid = 1'b0, done_rts = 1'b0, done_pe = 1'b0, done_fe = 1'b0, done_ovr = 1'b0;

  uart_rx_core #(.BAUD_DIV(16)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
    .parity_en(parity_en), .parity_type(parity_type), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_done(rx_done), .rx_valid(rx_valid),
    .parity_error(parity_error), .frame_error(frame_error),
    .overrun_error(overrun_error), .rts_n(rts_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt   = done_cnt + 1;
      done_cyc   = cyc;
      done_data  = rx_data;
      done_valid = rx_valid;
      done_rts   = rts_n;
      done_pe    = parity_error;
      done_fe    = frame_error;
      done_ovr   = overrun_error;
      $display("frame: cyc=%0d data=%h valid=%b rts_n=%b pe=%b fe=%b ovr=%b",
               cyc, rx_data, rx_valid, rts_n, parity_error, frame_error, overrun_error);
    end
    if (overrun_error) ovr_cnt = ovr_cnt + 1;
  end

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic pen,
                            input logic pbit, input int nstop, input logic stop_val);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (16) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      repeat (16) @(negedge clk);
    end
    if (pen) begin
      rx = pbit;
      repeat (16) @(negedge clk);
    end
    for (int k = 0; k < nstop; k++) begin
      rx = stop_val;
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic do_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] outs;
    repeat (3) @(negedge clk);
    outs = {rx_data, rx_done, rx_valid, parity_error, frame_error, overrun_error, rts_n};
    total++;
    if (outs !== 14'h0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (done_cnt !== 0) begin bad++; $display("FAIL reset_no_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_8n1();
    int d0 = done_cnt;
    data_bit_num = 2'b11; stop_bit_num = 1'b0; parity_en = 1'b0;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL 8n1_done_count: got %0d want 1", done_cnt - d0); end
    total++;
    if (done_cyc !== start_cyc + 155) begin bad++; $display("FAIL 8n1_latency: got %0d want %0d", done_cyc - start_cyc, 155); end
    total++;
    if (done_data !== 8'hA5) begin bad++; $display("FAIL 8n1_data: got %h want a5", done_data); end
    total++;
    if ({done_valid, done_rts} !== 2'b11) begin bad++; $display("FAIL 8n1_valid_rts: got %b want 11", {done_valid, done_rts}); end
    total++;
    if ({done_pe, done_fe} !== 2'b00) begin bad++; $display("FAIL 8n1_errors: got %b want 00", {done_pe, done_fe}); end
    do_ack();
    total++;
    if ({rx_valid, rts_n} !== 2'b00) begin bad++; $display("FAIL ack_clear: got %b want 00", {rx_valid, rts_n}); end
  endtask

  task automatic test_parity_7e2();
    int d0 = done_cnt;
    data_bit_num = 2'b10; stop_bit_num = 1'b1; parity_en = 1'b1; parity_type = 1'b0;
    fork
      send_frame(8'h55, 7, 1'b1, 1'b1, 2, 1'b1);
      begin
        repeat (30) @(negedge clk);
        data_bit_num = 2'b00; stop_bit_num = 1'b0; parity_en = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 1 || done_cyc !== start_cyc + 171) begin
      bad++; $display("FAIL 7e2_timing: got count=%0d lat=%0d want 1/171", done_cnt - d0, done_cyc - start_cyc);
    end
    total++;
    if (done_data !== 8'h55) begin bad++; $display("FAIL 7e2_data: got %h want 55", done_data); end
    total++;
    if ({done_pe, done_fe} !== 2'b10) begin bad++; $display("FAIL 7e2_errors: got %b want 10", {done_pe, done_fe}); end
    do_ack();
  endtask

  task automatic test_5o1();
    int d0 = done_cnt;
    data_bit_num = 2'b00; stop_bit_num = 1'b0; parity_en = 1'b1; parity_type = 1'b1;
    send_frame(8'hFF, 5, 1'b1, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 1 || done_cyc !== start_cyc + 123) begin
      bad++; $display("FAIL 5o1_timing: got count=%0d lat=%0d want 1/123", done_cnt - d0, done_cyc - start_cyc);
    end
    total++;
    if (done_data !== 8'h1F) begin bad++; $display("FAIL 5o1_data: got %h want 1f", done_data); end
    total++;
    if ({done_pe, done_fe} !== 2'b00) begin bad++; $display("FAIL 5o1_errors: got %b want 00", {done_pe, done_fe}); end
    do_ack();
    data_bit_num = 2'b11; parity_en = 1'b0; parity_type = 1'b0;
  endtask

  task automatic test_frame_error();
    int d0 = done_cnt;
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0);
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL ferr_done_count: got %0d want 1", done_cnt - d0); end
    total++;
    if (done_data !== 8'h3C) begin bad++; $display("FAIL ferr_data: got %h want 3c", done_data); end
    total++;
    if ({done_pe, done_fe} !== 2'b01) begin bad++; $display("FAIL ferr_errors: got %b want 01", {done_pe, done_fe}); end
    do_ack();
  endtask

  task automatic test_glitch();
    int d0 = done_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (6) @(negedge clk);
    send_frame(8'h96, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 1) begin bad++; $display("FAIL glitch_done_count: got %0d want 1", done_cnt - d0); end
    total++;
    if (done_data !== 8'h96 || done_cyc !== start_cyc + 155) begin
      bad++; $display("FAIL glitch_followup: got %h lat=%0d want 96 lat=155", done_data, done_cyc - start_cyc);
    end
    do_ack();
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    int o0 = ovr_cnt;
    send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
    total++;
    if (done_data !== 8'h11 || done_ovr !== 1'b0) begin
      bad++; $display("FAIL b2b_first: got %h ovr=%b want 11 ovr=0", done_data, done_ovr);
    end
    send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); end
    total++;
    if (done_data !== 8'h22 || done_ovr !== 1'b1) begin
      bad++; $display("FAIL b2b_overrun: got %h ovr=%b want 22 ovr=1", done_data, done_ovr);
    end
    total++;
    if (ovr_cnt - o0 !== 1 || rx_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_pulse: got ovr_pulses=%0d valid=%b want 1/1", ovr_cnt - o0, rx_valid);
    end
  endtask

  task automatic test_ack_collision();
    int o0 = ovr_cnt;
    fork
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
      begin
        repeat (154) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    total++;
    if (done_data !== 8'h5A || done_valid !== 1'b1 || done_ovr !== 1'b0) begin
      bad++; $display("FAIL collision: got %h valid=%b ovr=%b want 5a 1 0", done_data, done_valid, done_ovr);
    end
    total++;
    if (ovr_cnt !== o0 || rx_valid !== 1'b1) begin
      bad++; $display("FAIL collision_hold: got ovr_pulses=%0d valid=%b want 0/1", ovr_cnt - o0, rx_valid);
    end
  endtask

  task automatic test_reset_midframe();
    logic [13:0] outs;
    int d0;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (46) @(negedge clk);
    rst = 1'b1;
    #1;
    outs = {rx_data, rx_done, rx_valid, parity_error, frame_error, overrun_error, rts_n};
    total++;
    if (outs !== 14'h0) begin bad++; $display("FAIL midframe_reset_outputs: got %h want 0", outs); end
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    outs = {rx_data, rx_done, rx_valid, parity_error, frame_error, overrun_error, rts_n};
    total++;
    if (outs !== 14'h0 || done_cnt !== d0) begin
      bad++; $display("FAIL midframe_discard: got %h done=%0d want 0 done=0", outs, done_cnt - d0);
    end
    send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (done_data !== 8'h81 || done_cyc !== start_cyc + 155 || done_fe !== 1'b0) begin
      bad++; $display("FAIL after_reset_frame: got %h lat=%0d fe=%b want 81 155 0", done_data, done_cyc - start_cyc, done_fe);
    end
    do_ack();
  endtask

  task automatic test_low_at_release();
    int d0;
    rst = 1'b1;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    rst = 1'b0;
    repeat (200) @(negedge clk);
    total++;
    if (done_cnt !== d0 || rx_valid !== 1'b0) begin
      bad++; $display("FAIL low_release: got done=%0d valid=%b want 0/0", done_cnt - d0, rx_valid);
    end
    rx = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h42, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (done_cnt - d0 !== 1 || done_data !== 8'h42) begin
      bad++; $display("FAIL low_release_followup: got done=%0d data=%h want 1 42", done_cnt - d0, done_data);
    end
    do_ack();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_8n1();
    test_parity_7e2();
    test_5o1();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_ack_collision();
    test_reset_midframe();
    test_low_at_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
